// File: rtl/signature_sequencer.sv
// Self-test sequencer: drives a seeded 8-bit LFSR stream into the student
// circuit and folds its responses into a 16-bit CRC-style signature.
module signature_sequencer #(
  parameter int unsigned NUM_VECTORS = 256,
  parameter int unsigned LATENCY     = 0
) (
  input  logic        clk,
  input  logic        clear_n,
  input  logic        start,
  input  logic [7:0]  seed,
  input  logic [7:0]  cct_output,
  output logic        cct_clear,
  output logic [7:0]  cct_input,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);
  localparam logic [1:0]  LAT      = 2'(LATENCY);

  state_t      state_q, state_d;
  logic [7:0]  lfsr_q,  lfsr_d;
  logic [15:0] acc_q,   acc_d;
  logic [15:0] sig_q,   sig_d;
  logic [15:0] vec_q,   vec_d;
  logic [15:0] smp_q,   smp_d;
  logic [1:0]  lat_q,   lat_d;
  logic        clr_q,   clr_d;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  function automatic logic [15:0] sig_step(input logic [15:0] s, input logic [7:0] r);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {8'h00, r};
  endfunction

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    acc_d   = acc_q;
    sig_d   = sig_q;
    vec_d   = vec_q;
    smp_d   = smp_q;
    lat_d   = lat_q;
    clr_d   = clr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLEAR;
          lfsr_d  = (seed == 8'h00) ? 8'h01 : seed;
          acc_d   = 16'h0000;
          vec_d   = 16'h0000;
          smp_d   = 16'h0000;
          lat_d   = 2'd0;
          clr_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (clr_q) begin
          state_d = ST_RUN;
        end else begin
          clr_d = 1'b1;
        end
      end
      ST_RUN: begin
        // The last vector stays on cct_input while the pipeline drains
        if (vec_q != LAST_IDX) begin
          vec_d  = vec_q + 16'd1;
          lfsr_d = lfsr_next(lfsr_q);
        end else begin
          vec_d = vec_q;
        end
        if (lat_q != LAT) begin
          lat_d = lat_q + 2'd1;
        end else begin
          acc_d = sig_step(acc_q, cct_output);
          if (smp_q == LAST_IDX) begin
            state_d = ST_DONE;
            sig_d   = sig_step(acc_q, cct_output);
          end else begin
            smp_d = smp_q + 16'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        sig_d   = acc_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= ST_IDLE;
      lfsr_q  <= 8'h00;
      acc_q   <= 16'h0000;
      sig_q   <= 16'h0000;
      vec_q   <= 16'h0000;
      smp_q   <= 16'h0000;
      lat_q   <= 2'd0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      acc_q   <= acc_d;
      sig_q   <= sig_d;
      vec_q   <= vec_d;
      smp_q   <= smp_d;
      lat_q   <= lat_d;
      clr_q   <= clr_d;
    end
  end

  assign cct_clear = (state_q != ST_RUN);
  assign cct_input = (state_q == ST_IDLE) ? 8'h00 : lfsr_q;
  assign busy      = (state_q == ST_CLEAR) || (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign signature = sig_q;

endmodule

// File: tb/tb_signature_sequencer.sv
// Randomized scoreboard bench for signature_sequencer with a stub student
// circuit of configurable response function and pipeline depth.
module tb_signature_sequencer;
  localparam int N = 6;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        clear_n, start;
  logic [7:0]  seed, cct_output, cct_input;
  logic        cct_clear, busy, done;
  logic [15:0] signature;

  int tests = 0, fails = 0, cyc = 0, done_cnt = 0;
  int          mode_v = 0;
  logic [7:0]  key_v = 8'h00;
  int          vec_exp[$], clr_exp[$], sig_exp[$], cyc_exp[$];
  logic        chk_sig = 1'b0;
  int          sig_pending = 0;
  int          last_sig = 0;

  signature_sequencer #(.NUM_VECTORS(N), .LATENCY(L)) dut (
    .clk(clk), .clear_n(clear_n), .start(start), .seed(seed),
    .cct_output(cct_output), .cct_clear(cct_clear), .cct_input(cct_input),
    .busy(busy), .done(done), .signature(signature)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] resp(input logic [7:0] v, input int m, input logic [7:0] k);
    case (m)
      0: return v;
      1: return 8'h01;
      2: return v ^ k;
      default: return 8'(v * 3 + k);
    endcase
  endfunction

  // Stub student circuit: response function behind L register stages
  logic [7:0] pipe [3];
  always @(posedge clk) begin
    pipe[0] <= resp(cct_input, mode_v, key_v);
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  generate
    if (L == 0) begin : g_comb
      assign cct_output = resp(cct_input, mode_v, key_v);
    end else begin : g_pipe
      assign cct_output = pipe[L-1];
    end
  endgenerate

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: whole run computed from the rules with plain arithmetic
  task automatic model_push(input int s, input int m, input int k, input int acc_cyc, output int sig);
    int r, fb, v;
    int vecs[$];
    r = (s == 0) ? 1 : s;
    for (int i = 0; i < N; i++) begin
      vecs.push_back(r);
      fb = ((r >> 7) ^ (r >> 5) ^ (r >> 4) ^ (r >> 3)) & 1;
      r  = ((r << 1) | fb) & 255;
    end
    for (int i = 0; i < 2; i++) begin vec_exp.push_back(vecs[0]); clr_exp.push_back(1); end
    for (int i = 0; i < N + L; i++) begin
      vec_exp.push_back(vecs[(i < N) ? i : N - 1]);
      clr_exp.push_back(0);
    end
    sig = 0;
    for (int i = 0; i < N; i++) begin
      v   = int'(resp(8'(vecs[i]), m, 8'(k)));
      sig = ((sig << 1) & 16'hFFFF) ^ (((sig & 16'h8000) != 0) ? 16'h1021 : 0) ^ v;
    end
    sig_exp.push_back(sig);
    cyc_exp.push_back(acc_cyc + (2 + N + L + 1) - 1);
  endtask

  // Monitor: pops expectations whenever the DUT presents a busy or done cycle
  always @(negedge clk) begin
    if (!clear_n) begin
      chk_sig <= 1'b0;
    end else begin
      if (chk_sig) begin
        check("signature", signature, sig_pending);
        chk_sig <= 1'b0;
      end
      if (busy) begin
        if (vec_exp.size() == 0) check("busy_extra", busy, 0);
        else begin
          check("cct_input", cct_input, vec_exp.pop_front());
          check("cct_clear_busy", cct_clear, clr_exp.pop_front());
        end
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        check("done_busy", busy, 0);
        check("done_clear", cct_clear, 1);
        if (sig_exp.size() == 0) check("unexpected_done", done, 0);
        else begin
          sig_pending <= sig_exp.pop_front();
          chk_sig     <= 1'b1;
          check("done_cycle", cyc, cyc_exp.pop_front());
        end
      end
    end
  end

  task automatic wait_done(input string name);
    int base = done_cnt;
    int n = 0;
    while (done_cnt == base && n < 400) begin @(posedge clk); n++; end
    check({name, "_done_seen"}, (done_cnt != base), 1);
  endtask

  task automatic do_run(input int s, input int m, input int k);
    int sig;
    @(posedge clk); #1 start = 1'b1; seed = 8'(s); mode_v = m; key_v = 8'(k);
    @(posedge clk); #1;
    check("sig_hold", signature, last_sig);
    model_push(s, m, k, cyc, sig);
    seed = 8'($urandom);
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("run");
    last_sig = sig;
  endtask

  task automatic reset_run(input int s);
    int sig, base;
    @(posedge clk); #1 start = 1'b1; seed = 8'(s); mode_v = 0;
    @(posedge clk); #1 start = 1'b0;
    model_push(s, 0, 0, cyc, sig);
    repeat (5) @(posedge clk);
    #2 clear_n = 1'b0;
    #1;
    check("rst_cct_clear", cct_clear, 1);
    check("rst_cct_input", cct_input, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_signature", signature, 0);
    vec_exp.delete(); clr_exp.delete(); sig_exp.delete(); cyc_exp.delete();
    base = done_cnt;
    repeat (20) @(posedge clk);
    check("no_done_in_reset", done_cnt, base);
    #1 clear_n = 1'b1;
    last_sig = 0;
  endtask

  task automatic b2b_runs(input int s, input int k);
    int sig, acc;
    @(posedge clk); #1 start = 1'b1; seed = 8'(s); mode_v = 2; key_v = 8'(k);
    @(posedge clk); #1 acc = cyc;
    model_push(s, 2, k, acc, sig);
    model_push(s, 2, k, acc + N + L + 4, sig);
    wait_done("b2b_first");
    @(posedge clk); #1 start = 1'b0;
    wait_done("b2b_second");
    check("b2b_signature", signature, sig);
    last_sig = sig;
  endtask

  initial begin
    clear_n = 1'b0; start = 1'b0; seed = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("init_cct_clear", cct_clear, 1);
    check("init_cct_input", cct_input, 0);
    check("init_busy", busy, 0);
    check("init_done", done, 0);
    check("init_signature", signature, 0);
    clear_n = 1'b1;

    do_run(8'hAA, 0, 0);
    check("kat_seed_aa", signature, 16'h1515);
    do_run(8'h00, 0, 0);
    do_run(8'hAA, 1, 0);
    reset_run(8'h5A);
    do_run(8'h5A, 0, 0);
    for (int i = 0; i < 12; i++) begin
      do_run(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
    end
    b2b_runs(8'h3C, 8'hC3);
    repeat (3) @(posedge clk);
    check("leftover_vectors", vec_exp.size(), 0);
    check("leftover_signatures", sig_exp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
